// File: rtl/mem_wb_sram_stage_if.sv
// Bundle between the MEM stage, its neighbours (EXE/MEM, register file) and the 16-bit SRAM.
interface mem_wb_sram_stage_if #(
   parameter int unsigned ADDR_W = 18
);
   logic              exe_valid;
   logic              mem_r_en;
   logic              mem_w_en;
   logic              wb_en_in;
   logic [3:0]        dest_in;
   logic [31:0]       alu_res;
   logic [31:0]       st_val;
   logic              freeze;
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_wdata;
   logic              sram_we_n;
   logic [15:0]       sram_rdata;
   logic              wb_en;
   logic [3:0]        wb_dest;
   logic [31:0]       wb_value;
   logic              mem_fault;

   modport master (
      output exe_valid, mem_r_en, mem_w_en, wb_en_in, dest_in, alu_res, st_val, sram_rdata,
      input  freeze, sram_addr, sram_wdata, sram_we_n, wb_en, wb_dest, wb_value, mem_fault
   );

   modport slave (
      input  exe_valid, mem_r_en, mem_w_en, wb_en_in, dest_in, alu_res, st_val, sram_rdata,
      output freeze, sram_addr, sram_wdata, sram_we_n, wb_en, wb_dest, wb_value, mem_fault
   );
endinterface

// File: rtl/mem_wb_sram_stage.sv
// MEM stage + MEM/WB register: LDR/STR as two halfword phases on a 16-bit SRAM with wait states.
// Optional define MEM_ADDR_CHECK_EN: range-check the SRAM word and raise a sticky mem_fault.
module mem_wb_sram_stage #(
   parameter int unsigned ADDR_W    = 18,
   parameter int unsigned BASE_ADDR = 1024,
   parameter int unsigned WAIT      = 1
) (
   input logic                clk,
   input logic                rst,
   mem_wb_sram_stage_if.slave bus
);
   localparam int unsigned WORD_W = ADDR_W - 1;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LO = 2'd1, S_HI = 2'd2, S_DONE = 2'd3} state_t;

   state_t            state;
   state_t            state_nx;
   logic [CNT_W-1:0]  cnt;
   logic              op_load;
   logic              lat_wb_en;
   logic [3:0]        lat_dest;
   logic [WORD_W-1:0] lat_word;
   logic [31:0]       lat_st;
   logic [31:0]       data;
   logic              wb_en_q;
   logic [3:0]        wb_dest_q;
   logic [31:0]       wb_value_q;
   logic              fault_q;

   logic              access_c;
   logic              in_range_c;
   logic              start_c;
   logic              phase_last_c;
   logic [31:0]       offset_c;
   logic [WORD_W-1:0] word_c;

   assign access_c     = bus.exe_valid & (bus.mem_r_en | bus.mem_w_en);
   assign offset_c     = bus.alu_res - 32'(BASE_ADDR);
   assign word_c       = offset_c[WORD_W+1:2];
   assign phase_last_c = (cnt == CNT_W'(WAIT));

   // Byte-lane bits are ignored; word bits above the SRAM are only looked at by the range check.
   logic unused_offset;
   assign unused_offset = ^{offset_c[1:0], offset_c[31:WORD_W+2]};

`ifdef MEM_ADDR_CHECK_EN
   assign in_range_c = (offset_c[31:WORD_W+2] == '0);
`else
   assign in_range_c = 1'b1;
`endif

   assign start_c = access_c & in_range_c;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start_c) state_nx = S_LO;
         S_LO:    if (phase_last_c) state_nx = S_HI;
         S_HI:    if (phase_last_c) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // SRAM strobes and the upstream stall; freeze in IDLE is the combinational access request.
   always_comb begin
      bus.freeze     = 1'b0;
      bus.sram_addr  = '0;
      bus.sram_wdata = '0;
      bus.sram_we_n  = 1'b1;
      case (state)
         S_IDLE: bus.freeze = start_c;
         S_LO: begin
            bus.freeze    = 1'b1;
            bus.sram_addr = {lat_word, 1'b0};
            if (!op_load) begin
               bus.sram_wdata = lat_st[15:0];
               bus.sram_we_n  = 1'b0;
            end
         end
         S_HI: begin
            bus.freeze    = 1'b1;
            bus.sram_addr = {lat_word, 1'b1};
            if (!op_load) begin
               bus.sram_wdata = lat_st[31:16];
               bus.sram_we_n  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Access latch, wait-state counter and load data assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         op_load   <= 1'b0;
         lat_wb_en <= 1'b0;
         lat_dest  <= '0;
         lat_word  <= '0;
         lat_st    <= '0;
         data      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_c) begin
                  op_load   <= bus.mem_r_en;
                  lat_wb_en <= bus.wb_en_in;
                  lat_dest  <= bus.dest_in;
                  lat_word  <= word_c;
                  lat_st    <= bus.st_val;
                  cnt       <= '0;
               end
            end
            S_LO: begin
               if (phase_last_c) begin
                  cnt <= '0;
                  if (op_load) data[15:0] <= bus.sram_rdata;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_HI: begin
               if (phase_last_c) begin
                  cnt <= '0;
                  if (op_load) data[31:16] <= bus.sram_rdata;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // MEM/WB register: bubble while frozen, load result after DONE, pass-through otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en_q    <= 1'b0;
         wb_dest_q  <= '0;
         wb_value_q <= '0;
      end else if (bus.freeze) begin
         wb_en_q <= 1'b0;
      end else begin
         case (state)
            S_DONE: begin
               wb_en_q <= op_load & lat_wb_en;
               if (op_load) begin
                  wb_dest_q  <= lat_dest;
                  wb_value_q <= data;
               end
            end
            S_IDLE: begin
               if (access_c) begin
                  // Only reachable for a range-rejected access.
                  if (bus.mem_r_en) begin
                     wb_en_q    <= bus.wb_en_in;
                     wb_dest_q  <= bus.dest_in;
                     wb_value_q <= '0;
                  end else begin
                     wb_en_q <= 1'b0;
                  end
               end else begin
                  wb_en_q    <= bus.exe_valid & bus.wb_en_in;
                  wb_dest_q  <= bus.dest_in;
                  wb_value_q <= bus.alu_res;
               end
            end
            default: wb_en_q <= 1'b0;
         endcase
      end
   end

`ifdef MEM_ADDR_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)                                             fault_q <= 1'b0;
      else if (state == S_IDLE && access_c && !in_range_c) fault_q <= 1'b1;
   end
`else
   assign fault_q = 1'b0;
`endif

   assign bus.wb_en     = wb_en_q;
   assign bus.wb_dest   = wb_dest_q;
   assign bus.wb_value  = wb_value_q;
   assign bus.mem_fault = fault_q;
endmodule
